// File: rtl/isqrt_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_pipe_if
//  Description : Request/result bundle for the pipelined integer square root.
//                The master drives radicands and the slave returns results.
//  Revision    : 1.0  initial release
// ============================================================================
interface isqrt_pipe_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  logic        busy;

  modport master (output x_vld, output x, input y_vld, input y, input busy);
  modport slave  (input x_vld, input x, output y_vld, output y, output busy);
endinterface
`default_nettype wire

// File: rtl/isqrt_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_pipe
//  Description : Fully pipelined 32-bit integer square root, y = floor(sqrt(x)).
//                Radix-4 restoring digit recurrence, 16 iterations, MSB pair
//                first, STAGES_PER_REG iterations between pipeline registers.
//                One result per cycle, latency 16/STAGES_PER_REG cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module isqrt_pipe #(
  parameter int STAGES_PER_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  isqrt_pipe_if.slave bus
);

  localparam int LAT = 16 / STAGES_PER_REG;

  // Only divisors of 16 up to 16 give a whole number of register stages.
  if (!(STAGES_PER_REG == 1 || STAGES_PER_REG == 2 || STAGES_PER_REG == 4 ||
        STAGES_PER_REG == 8 || STAGES_PER_REG == 16)) begin : g_param_check
    $error("isqrt_pipe: STAGES_PER_REG must be 1, 2, 4, 8 or 16");
  end

  // r_vld[0] is the input-capture stage, r_vld[LAT] the output stage.
  logic [LAT:0] r_vld;
  logic [31:0]  r_x_cap;
  logic [15:0]  r_y;

  // Chain between stages: element k is what stage k+1 consumes.
  logic [31:0]  w_x_c    [0:LAT-1];
  logic [17:0]  w_rem_c  [0:LAT-1];
  logic [15:0]  w_root_c [0:LAT-1];

  // Valid bits advance every cycle; reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[LAT-1:0], bus.x_vld};
    end
  end

  // Radicand capture loads only for a valid request.
  always_ff @(posedge clk) begin
    if (bus.x_vld) begin
      r_x_cap <= bus.x;
    end
  end

  assign w_x_c[0]    = r_x_cap;
  assign w_rem_c[0]  = '0;
  assign w_root_c[0] = '0;

  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    logic [31:0] w_x_nxt;
    logic [17:0] w_rem_nxt;
    logic [15:0] w_root_nxt;

    // STAGES_PER_REG recurrence steps; the top radicand pair is consumed
    // and shifted out each step. Before the shift rem <= 2*root < 2^16,
    // so dropping rem[17:16] on the shift never loses information.
    always_comb begin
      w_x_nxt    = w_x_c[k-1];
      w_rem_nxt  = w_rem_c[k-1];
      w_root_nxt = w_root_c[k-1];
      for (int j = 0; j < STAGES_PER_REG; j++) begin
        w_rem_nxt = {w_rem_nxt[15:0], w_x_nxt[31:30]};
        if (w_rem_nxt >= {w_root_nxt, 2'b01}) begin
          w_rem_nxt  = w_rem_nxt - {w_root_nxt, 2'b01};
          w_root_nxt = {w_root_nxt[14:0], 1'b1};
        end else begin
          w_root_nxt = {w_root_nxt[14:0], 1'b0};
        end
        w_x_nxt = {w_x_nxt[29:0], 2'b00};
      end
    end

    if (k < LAT) begin : g_mid
      logic [31:0] r_x;
      logic [17:0] r_rem;
      logic [15:0] r_root;

      // Intermediate stage data loads only behind a valid request.
      always_ff @(posedge clk) begin
        if (r_vld[k-1]) begin
          r_x    <= w_x_nxt;
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
        end
      end

      assign w_x_c[k]    = r_x;
      assign w_rem_c[k]  = r_rem;
      assign w_root_c[k] = r_root;
    end else begin : g_last
      // Result register holds its value between results and clears on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_y <= '0;
        end else if (r_vld[k-1]) begin
          r_y <= w_root_nxt;
        end
      end
    end
  end

  assign bus.y_vld = r_vld[LAT];
  assign bus.y     = r_y;
  assign bus.busy  = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_pipe
//  Description : Self-checking bench for isqrt_pipe. Four instances
//                (STAGES_PER_REG = 1, 2, 4, 16) see the same stimulus and are
//                checked every cycle against a floor-sqrt reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_isqrt_pipe;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  localparam int NDUT = 4;
  int LATS [NDUT] = '{16, 8, 4, 1};

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;

  int          n_chk;
  int          n_fail;
  int          cyc;
  bit          started;
  int          vld_cnt0;
  exp_t        q [NDUT][$];
  logic [15:0] last_y [NDUT];

  isqrt_pipe_if i0 ();
  isqrt_pipe_if i1 ();
  isqrt_pipe_if i2 ();
  isqrt_pipe_if i3 ();

  assign i0.x_vld = x_vld;  assign i0.x = x;
  assign i1.x_vld = x_vld;  assign i1.x = x;
  assign i2.x_vld = x_vld;  assign i2.x = x;
  assign i3.x_vld = x_vld;  assign i3.x = x;

  isqrt_pipe #(.STAGES_PER_REG(1))  u_dut_s1  (.clk(clk), .rst(rst), .bus(i0));
  isqrt_pipe #(.STAGES_PER_REG(2))  u_dut_s2  (.clk(clk), .rst(rst), .bus(i1));
  isqrt_pipe #(.STAGES_PER_REG(4))  u_dut_s4  (.clk(clk), .rst(rst), .bus(i2));
  isqrt_pipe #(.STAGES_PER_REG(16)) u_dut_s16 (.clk(clk), .rst(rst), .bus(i3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: floating-point estimate refined with exact integer bounds.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint r;
    longint lv;
    lv = longint'(v);
    r  = longint'($floor($sqrt(real'(lv))));
    while (r * r > lv) r--;
    while ((r + 1) * (r + 1) <= lv) r++;
    return r[15:0];
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model side: every accepted request is due LAT cycles after its edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int d = 0; d < NDUT; d++) begin
        q[d].delete();
        last_y[d] = 16'h0;
      end
      vld_cnt0 = 0;
      started  = 1'b1;
    end else if (x_vld) begin
      for (int d = 0; d < NDUT; d++) begin
        q[d].push_back('{cyc + LATS[d], ref_sqrt(x)});
      end
    end
  end

  task automatic chk_dut(input int d, input logic yv, input logic [15:0] yy,
                         input logic bz);
    logic exp_v;
    exp_v = (q[d].size() > 0) && (q[d][0].due == cyc);
    cmp($sformatf("busy[s%0d]", d), longint'(bz), longint'(q[d].size() > 0));
    cmp($sformatf("y_vld[s%0d]", d), longint'(yv), longint'(exp_v));
    if (exp_v) begin
      cmp($sformatf("y[s%0d]", d), longint'(yy), longint'(q[d][0].val));
      last_y[d] = q[d][0].val;
    end else begin
      cmp($sformatf("y_hold[s%0d]", d), longint'(yy), longint'(last_y[d]));
    end
    while (q[d].size() > 0 && q[d][0].due <= cyc) void'(q[d].pop_front());
  endtask

  // Compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk_dut(0, i0.y_vld, i0.y, i0.busy);
      chk_dut(1, i1.y_vld, i1.y, i1.busy);
      chk_dut(2, i2.y_vld, i2.y, i2.busy);
      chk_dut(3, i3.y_vld, i3.y, i3.busy);
      if (i0.y_vld) vld_cnt0++;
    end
  end

  task automatic drv(input logic v, input logic [31:0] d);
    @(negedge clk);
    rst   = 1'b0;
    x_vld = v;
    x     = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, $urandom);
  endtask

  logic [31:0] singles [7] = '{32'h0, 32'h1, 32'd15, 32'd16, 32'hFFFFFFFF,
                               32'hFFFE0001, 32'hFFFE0000};
  logic [15:0] single_y [7] = '{16'h0, 16'h1, 16'd3, 16'd4, 16'hFFFF,
                                16'hFFFF, 16'hFFFE};
  bit gap_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int k;
    n_chk = 0; n_fail = 0; cyc = 0; started = 1'b0; vld_cnt0 = 0;
    rst = 1'b1; x_vld = 1'b0; x = 32'h0;

    // Pin the reference model to hand-computed values.
    for (int i = 0; i < 7; i++)
      cmp($sformatf("model_pin[%0d]", i), longint'(ref_sqrt(singles[i])),
          longint'(single_y[i]));
    cmp("model_pin_144", longint'(ref_sqrt(32'd144)), 12);

    repeat (3) @(negedge clk);

    // Single requests, each drained before the next.
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, singles[i]);
      idle(20);
    end

    // Burst of 100 random requests.
    for (int i = 0; i < 100; i++) drv(1'b1, $urandom);
    idle(20);

    // Gapped pattern, then random gaps.
    for (int i = 0; i < 7; i++) drv(gap_pat[i], $urandom);
    idle(20);
    for (int i = 0; i < 200; i++) drv(1'($urandom_range(0, 1)), $urandom);
    idle(20);

    // Reset in the middle of a stream.
    for (int i = 0; i < 4; i++) drv(1'b1, $urandom);
    @(negedge clk);
    rst = 1'b1; x_vld = 1'b1; x = $urandom;
    drv(1'b1, 32'd144);
    idle(25);
    cmp("reset_one_result", longint'(vld_cnt0), 1);

    // Perfect squares and their predecessors.
    for (k = 0; k < 1024; k++) begin
      drv(1'b1, 32'(k * k));
      if (k > 0) drv(1'b1, 32'(k * k - 1));
    end
    for (int i = 0; i < 64; i++) begin
      k = (i == 0) ? 65535 : int'($urandom_range(1024, 65535));
      drv(1'b1, 32'(longint'(k) * longint'(k)));
      drv(1'b1, 32'(longint'(k) * longint'(k) - 1));
    end
    idle(25);

    for (int d = 0; d < NDUT; d++)
      cmp($sformatf("drained[s%0d]", d), longint'(q[d].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isqrt_pipe.md
ISQRT_PIPE -- requirements
Module: isqrt_pipe

Interface
REQ-001 Parameter: STAGES_PER_REG, default 1, root iterations computed between consecutive pipeline registers; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 x_vld  input  1  request valid; x sampled on every rising edge where x_vld=1.
REQ-005 x  input  32  unsigned radicand.
REQ-006 y_vld  output  1  result valid, one-cycle pulse per accepted request.
REQ-007 y  output  16  unsigned floor(sqrt(x)) of the corresponding request.
REQ-008 busy  output  1  high while any accepted request has not yet produced y_vld.

Function
REQ-009 The block SHALL compute y = floor(sqrt(x)) exactly for all 2^32 inputs, using a 16-iteration digit-by-digit (radix-4 restoring) algorithm, MSB pair first.
REQ-010 Iteration i (i = 15 down to 0) SHALL: rem = (rem << 2) | x[2i+1:2i]; trial = (root << 2) | 1; if rem >= trial then rem = rem - trial and root = (root << 1) | 1, else root = root << 1; rem and root start at 0.
REQ-011 The remainder SHALL be carried at 18 bits and the partial root at 16 bits; no intermediate truncation SHALL alter the result.
REQ-012 Iterations SHALL be grouped STAGES_PER_REG per register stage; latency L = 16 / STAGES_PER_REG cycles.
REQ-013 A request sampled at edge n SHALL produce y_vld=1 with its result on the interval after edge n+L (L=16 at default).
REQ-014 Throughput SHALL be one request per cycle; back-to-back x_vld SHALL yield back-to-back y_vld in request order, no gaps, no reordering.
REQ-015 No backpressure exists; every accepted request SHALL produce exactly one y_vld pulse, and no y_vld SHALL occur without a request.
REQ-016 Each stage SHALL carry a valid bit alongside remaining radicand bits, rem and root; data registers of a stage SHALL load only when the incoming valid is 1 (clock-gating-friendly).
REQ-017 When y_vld=0, y SHALL hold its last driven value (stable between results).
REQ-018 busy SHALL equal the OR of all stage valid bits including the input-capture stage, combinationally from registers.
REQ-019 Idle cycles (x_vld=0) inserted between requests SHALL appear as identical idle gaps on y_vld.
REQ-020 Illegal STAGES_PER_REG SHALL cause an elaboration-time error.

Reset
REQ-021 While rst=1 all stage valid bits SHALL clear, y_vld=0, y=0, busy=0; x_vld is ignored during reset.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight requests: no y_vld for any request sampled before or during reset.
REQ-023 The first request sampled on the first edge after rst deasserts SHALL complete normally with latency L.
REQ-024 Stage data registers need no reset; their contents SHALL never reach y without an accompanying valid.

Verification
REQ-025 Single requests, default parameter: x=0 -> y=0; x=1 -> y=1; x=15 -> y=3; x=16 -> y=4; x=0xFFFFFFFF -> y=0xFFFF; x=0xFFFE0001 -> y=0xFFFF; x=0xFFFE0000 -> y=0xFFFE; each y_vld exactly 16 cycles after its x_vld.
REQ-026 Burst: 100 consecutive random x with x_vld=1 -> 100 consecutive y_vld pulses, in order, each equal to the reference floor-sqrt; busy high throughout, low 1 cycle after last y_vld.
REQ-027 Gapped stream: pattern vld 1,0,1,1,0,0,1 -> identical y_vld pattern delayed 16 cycles with correct values.
REQ-028 Reset mid-flight: issue 8 requests, assert rst 1 cycle at 5th cycle after first request, then x=144 -> only one y_vld ever, y=12, 16 cycles after x=144.
REQ-029 Parameter sweep STAGES_PER_REG = 1, 2, 4, 16: same random vector set -> identical results, latencies 16, 8, 4, 1.
REQ-030 Exhaustive perfect squares k*k, k = 0..65535, and k*k-1 for k >= 1 -> y = k and k-1 respectively.
